// File: rtl/mem_copy_dma_if.sv
// Memory-port bundle between the copy DMA (master) and one port of the
// dual-port word memory (slave).
//   mem_addr   : request word address
//   mem_wdata  : write data (to memory din)
//   mem_wr     : byte write strobes, 0 = read, 4'hF = full-word write
//   mem_enable : request valid, one cycle per request
//   mem_rdata  : read data (from memory dout)
//   mem_ready  : response valid
interface mem_copy_dma_if #(
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wr;
  logic                 mem_enable;
  logic [31:0]          mem_rdata;
  logic                 mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_wr, mem_enable,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wr, mem_enable,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-copy DMA initiator. Copies `length` words from src_addr upward to
// dst_addr upward, one read followed by one write per word, over the
// memory enable/ready port. Addresses wrap modulo 2**ADDR_SIZE; a responder
// that stays silent for TIMEOUT cycles aborts the transfer with a sticky error.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : start pulse, only honoured while idle
//   src_addr   : first source word address
//   dst_addr   : first destination word address
//   length     : number of words (0..2**ADDR_SIZE)
//   busy       : transfer in progress
//   done       : one-cycle completion pulse
//   error      : sticky timeout flag, cleared by the next accepted start
//   mem        : memory port (master side)
module mem_copy_dma #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] src_addr,
  input  logic [ADDR_SIZE-1:0] dst_addr,
  input  logic [ADDR_SIZE:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  mem_copy_dma_if.master       mem
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN, ERR
  } state_t;

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_SIZE:0]   CNT_ONE   = 1;
  localparam logic [ADDR_SIZE:0]   CNT_ZERO  = '0;
  localparam logic [7:0]           WAIT_LAST = 8'(TIMEOUT - 1);

  state_t               state_q;
  logic [ADDR_SIZE-1:0] src_q;
  logic [ADDR_SIZE-1:0] dst_q;
  logic [ADDR_SIZE:0]   cnt_q;
  logic [7:0]           wait_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [31:0]          wdata_q;   // also serves as the captured read word
  logic [3:0]           wr_q;
  logic                 en_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_wdata  = wdata_q;
  assign mem.mem_wr     = wr_q;
  assign mem.mem_enable = en_q;

  // Outputs are computed for the state being entered, so each state's
  // outputs are visible throughout the cycle that state occupies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= '0;
      en_q    <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      wr_q   <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            cnt_q   <= length;
            error_q <= 1'b0;
            if (length == CNT_ZERO) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              busy_q  <= 1'b1;
              en_q    <= 1'b1;
              addr_q  <= src_addr;
            end
          end
        end
        RD_REQ: begin
          state_q <= RD_WAIT;
          wait_q  <= '0;
        end
        RD_WAIT: begin
          if (mem.mem_ready) begin
            state_q <= WR_REQ;
            en_q    <= 1'b1;
            wr_q    <= 4'hF;
            addr_q  <= dst_q;
            wdata_q <= mem.mem_rdata;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        WR_REQ: begin
          state_q <= WR_WAIT;
          wait_q  <= '0;
        end
        WR_WAIT: begin
          if (mem.mem_ready) begin
            src_q <= src_q + ADDR_ONE;
            dst_q <= dst_q + ADDR_ONE;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              en_q    <= 1'b1;
              addr_q  <= src_q + ADDR_ONE;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        FIN:     state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: a behavioural memory responder with
// configurable latency/stall, expected read/write requests and done/error
// cycles queued at stimulus time and checked by a separate monitor.
module tb_mem_copy_dma;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   length;
  logic          busy, done, error;

  always #5 clk = ~clk;

  mem_copy_dma_if #(.ADDR_SIZE(AW)) bus ();

  mem_copy_dma #(.ADDR_SIZE(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .busy(busy), .done(done),
    .error(error), .mem(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem [256];
  int          lat = 0;
  bit          stall = 1'b0;
  bit          pending = 1'b0;
  int          delay = 0;
  logic [31:0] pend_data;
  bit          pl_en = 1'b0;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    bus.mem_ready <= 1'b0;
    if (pl_en) mem[pl_addr] = pl_data;
    if (bus.mem_enable && !stall) begin
      if (bus.mem_wr == 4'hF) mem[bus.mem_addr] = bus.mem_wdata;
      pend_data = mem[bus.mem_addr];
      if (lat == 0) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= pend_data;
      end else begin
        pending = 1'b1;
        delay   = lat;
      end
    end else if (pending) begin
      delay--;
      if (delay == 0) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= pend_data;
        pending = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [7:0]  exp_rd_q[$];
  logic [39:0] exp_wr_q[$];
  int          exp_done_q[$];
  int          exp_err_q[$];
  int          en_pulses = 0;
  logic        prev_en = 1'b0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    logic [39:0] w;
    if (rst) begin
      prev_en  = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (bus.mem_enable) begin
        en_pulses++;
        chk("enable_single_cycle", {31'b0, prev_en}, 32'd0);
        if (bus.mem_wr == 4'hF) begin
          if (exp_wr_q.size() == 0) flag("unexpected_write");
          else begin
            w = exp_wr_q.pop_front();
            chk("wr_addr", {24'b0, bus.mem_addr}, {24'b0, w[39:32]});
            chk("wr_data", bus.mem_wdata, w[31:0]);
          end
        end else begin
          chk("rd_strobe", {28'b0, bus.mem_wr}, 32'd0);
          if (exp_rd_q.size() == 0) flag("unexpected_read");
          else chk("rd_addr", {24'b0, bus.mem_addr}, {24'b0, exp_rd_q.pop_front()});
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) flag("unexpected_done");
        else chk("done_cycle", cyc, exp_done_q.pop_front());
      end
      if (error && !prev_err) begin
        if (exp_err_q.size() == 0) flag("unexpected_error");
        else chk("error_cycle", cyc, exp_err_q.pop_front());
      end
      prev_en  = bus.mem_enable;
      prev_err = error;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Returns e = cycle count just after the edge that samples start.
  task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n, output int e);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = n;
    @(posedge clk);
    #1;
    e = cyc;
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget && (exp_done_q.size() != 0 || exp_err_q.size() != 0); i++)
      @(posedge clk);
    if (exp_done_q.size() != 0 || exp_err_q.size() != 0) begin
      flag({name, "_timeout"});
      exp_done_q.delete();
      exp_err_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_rd_left"}, exp_rd_q.size(), 0);
    chk({name, "_wr_left"}, exp_wr_q.size(), 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  logic [31:0] wa[4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
  logic [31:0] ww[4] = '{32'hF00D_00FE, 32'hF00D_00FF, 32'hF00D_0000, 32'hF00D_0001};
  logic [31:0] wr3[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C};
  logic [7:0]  wrap_src[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    int e, en0;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_enable", {31'b0, bus.mem_enable}, 0);
    chk("rst_wr", {28'b0, bus.mem_wr}, 0);
    chk("rst_addr", {24'b0, bus.mem_addr}, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), wa[i]);
    for (int i = 0; i < 4; i++) poke(wrap_src[i], ww[i]);
    for (int i = 0; i < 3; i++) poke(8'h20 + 8'(i), wr3[i]);
    poke(8'hA0, 32'h5A5A_5A5A);

    // basic 4-word copy: done 4*4 edges after start edge
    en0 = en_pulses;
    kick(8'h10, 8'h80, 9'd4, e);
    chk("copy_busy", {31'b0, busy}, 1);
    for (int i = 0; i < 4; i++) begin
      exp_rd_q.push_back(8'h10 + 8'(i));
      exp_wr_q.push_back({8'h80 + 8'(i), wa[i]});
    end
    exp_done_q.push_back(e + 16);
    drain("copy", 60);
    for (int i = 0; i < 4; i++) chk("copy_mem", mem[8'h80 + 8'(i)], wa[i]);
    chk("copy_en_pulses", en_pulses - en0, 8);
    chk("copy_busy_after", {31'b0, busy}, 0);

    // zero length: done right after start, no requests
    en0 = en_pulses;
    kick(8'h33, 8'h44, 9'd0, e);
    exp_done_q.push_back(e);
    chk("len0_busy", {31'b0, busy}, 0);
    drain("len0", 10);
    chk("len0_en_pulses", en_pulses - en0, 0);

    // address wrap
    kick(8'hFE, 8'h40, 9'd4, e);
    for (int i = 0; i < 4; i++) begin
      exp_rd_q.push_back(wrap_src[i]);
      exp_wr_q.push_back({8'h40 + 8'(i), ww[i]});
    end
    exp_done_q.push_back(e + 16);
    drain("wrap", 60);
    for (int i = 0; i < 4; i++) chk("wrap_mem", mem[8'h40 + 8'(i)], ww[i]);

    // start re-pulsed while busy is ignored
    kick(8'h20, 8'h90, 9'd3, e);
    for (int i = 0; i < 3; i++) begin
      exp_rd_q.push_back(8'h20 + 8'(i));
      exp_wr_q.push_back({8'h90 + 8'(i), wr3[i]});
    end
    exp_done_q.push_back(e + 12);
    repeat (4) @(posedge clk);
    begin
      int e2;
      kick(8'h00, 8'hA0, 9'd1, e2);
    end
    drain("repulse", 40);
    for (int i = 0; i < 3; i++) chk("repulse_mem", mem[8'h90 + 8'(i)], wr3[i]);
    chk("repulse_untouched", mem[8'hA0], 32'h5A5A_5A5A);

    // responder silent on first read -> timeout after 15 wait cycles
    stall = 1'b1;
    kick(8'h10, 8'hB0, 9'd2, e);
    exp_rd_q.push_back(8'h10);
    exp_err_q.push_back(e + 16);
    drain("stall", 40);
    chk("stall_error", {31'b0, error}, 1);
    chk("stall_busy", {31'b0, busy}, 0);
    stall = 1'b0;
    kick(8'h10, 8'hB0, 9'd1, e);
    chk("restart_clears_error", {31'b0, error}, 0);
    exp_rd_q.push_back(8'h10);
    exp_wr_q.push_back({8'hB0, wa[0]});
    exp_done_q.push_back(e + 4);
    drain("restart", 20);
    chk("restart_mem", mem[8'hB0], wa[0]);

    // 3 extra cycles of responder latency: 10 cycles per word
    lat = 3;
    kick(8'h80, 8'hC0, 9'd3, e);
    for (int i = 0; i < 3; i++) begin
      exp_rd_q.push_back(8'h80 + 8'(i));
      exp_wr_q.push_back({8'hC0 + 8'(i), wa[i]});
    end
    exp_done_q.push_back(e + 30);
    drain("latency", 80);
    lat = 0;
    for (int i = 0; i < 3; i++) chk("latency_mem", mem[8'hC0 + 8'(i)], wa[i]);

    // reset during WR_WAIT of the second word
    kick(8'h10, 8'hD0, 9'd4, e);
    exp_rd_q.push_back(8'h10);
    exp_wr_q.push_back({8'hD0, wa[0]});
    exp_rd_q.push_back(8'h11);
    exp_wr_q.push_back({8'hD1, wa[1]});
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_enable", {31'b0, bus.mem_enable}, 0);
    chk("midrst_wr", {28'b0, bus.mem_wr}, 0);
    chk("midrst_addr", {24'b0, bus.mem_addr}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_idle_busy", {31'b0, busy}, 0);
    chk("midrst_rd_left", exp_rd_q.size(), 0);
    chk("midrst_wr_left", exp_wr_q.size(), 0);
    kick(8'h12, 8'hE0, 9'd1, e);
    exp_rd_q.push_back(8'h12);
    exp_wr_q.push_back({8'hE0, wa[2]});
    exp_done_q.push_back(e + 4);
    drain("post_rst", 20);
    chk("post_rst_mem", mem[8'hE0], wa[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
